// File: rtl/uart_frm_pkg.sv
// Shared state types and byte width for the UART command framer and its
// response serialiser.
package uart_frm_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {R_IDLE, R_COLLECT, R_READY} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_t;

endpackage

// File: rtl/uart_frm_tx.sv
// Response serialiser: sends a RESP_BYTES-wide word MS byte first through the
// byte UART, pacing each byte on a rising edge of tx_done.
module uart_frm_tx
  import uart_frm_pkg::*;
#(
  parameter int RESP_BYTES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BYTE_W*RESP_BYTES-1:0] resp,
  input  logic                         resp_vld,
  output logic                         resp_busy,
  output logic                         trmt,
  output logic [BYTE_W-1:0]            tx_data,
  input  logic                         tx_done,
  output logic                         resp_done
);

  localparam int RESP_W = BYTE_W * RESP_BYTES;
  localparam int REM_W  = $clog2(RESP_BYTES + 1);

  tx_state_t           r_state;
  logic [RESP_W-1:0]   r_shift;
  logic [REM_W-1:0]    r_rem;
  logic                r_txDonePrev;
  logic                r_trmt;
  logic                r_busy;
  logic                r_done;
  logic [BYTE_W-1:0]   r_txData;

  logic [RESP_W-1:0]   w_shiftNext;
  logic                w_txDoneRise;

  assign w_shiftNext  = r_shift << BYTE_W;
  assign w_txDoneRise = tx_done && !r_txDonePrev;

  // trmt is raised on entry to T_SEND so it lines up with the byte on tx_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= T_IDLE;
      r_shift      <= '0;
      r_rem        <= '0;
      r_txDonePrev <= 1'b0;
      r_trmt       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_txData     <= '0;
    end else begin
      r_txDonePrev <= tx_done;
      r_trmt       <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        T_IDLE: begin
          if (resp_vld) begin
            r_shift  <= resp;
            r_rem    <= REM_W'(RESP_BYTES);
            r_busy   <= 1'b1;
            r_trmt   <= 1'b1;
            r_txData <= resp[RESP_W-1 -: BYTE_W];
            r_state  <= T_SEND;
          end
        end
        T_SEND: r_state <= T_WAIT;
        T_WAIT: begin
          if (w_txDoneRise) begin
            if (r_rem > REM_W'(1)) begin
              r_shift  <= w_shiftNext;
              r_rem    <= r_rem - REM_W'(1);
              r_trmt   <= 1'b1;
              r_txData <= w_shiftNext[RESP_W-1 -: BYTE_W];
              r_state  <= T_SEND;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= T_IDLE;
            end
          end
        end
        default: r_state <= T_IDLE;
      endcase
    end
  end

  assign resp_busy = r_busy;
  assign trmt      = r_trmt;
  assign tx_data   = r_txData;
  assign resp_done = r_done;

endmodule

// File: rtl/uart_cmd_framer.sv
// Assembles CMD_BYTES UART bytes into one command word with an inter-byte
// timeout for resync, and forwards responses to the serialiser.
module uart_cmd_framer
  import uart_frm_pkg::*;
#(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_rdy,
  input  logic [BYTE_W-1:0]            rx_data,
  output logic                         clr_rx_rdy,
  output logic [BYTE_W*CMD_BYTES-1:0]  cmd,
  output logic                         cmd_rdy,
  input  logic                         clr_cmd_rdy,
  output logic                         frame_err,
  input  logic [BYTE_W*RESP_BYTES-1:0] resp,
  input  logic                         resp_vld,
  output logic                         resp_busy,
  output logic                         trmt,
  output logic [BYTE_W-1:0]            tx_data,
  input  logic                         tx_done,
  output logic                         resp_done
);

  localparam int CMD_W = BYTE_W * CMD_BYTES;
  localparam int CNT_W = $clog2(CMD_BYTES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);

  rx_state_t         r_rxState;
  logic [CMD_W-1:0]  r_cmd;
  logic              r_cmdRdy;
  logic              r_frameErr;
  logic [CNT_W-1:0]  r_byteCnt;
  logic [TO_W-1:0]   r_toCnt;

  logic              w_accept;
  logic              w_lastByte;
  logic              w_expired;
  logic [CMD_W-1:0]  w_cmdNext;

  // A byte sitting in the UART is never consumed while reset is asserted.
  assign w_accept   = rx_rdy && (r_rxState != R_READY) && !rst;
  assign w_lastByte = (r_byteCnt == CNT_W'(CMD_BYTES - 1));
  assign w_expired  = (r_toCnt == TO_W'(TIMEOUT_CYC - 1));

  generate
    if (CMD_BYTES == 1) begin : g_single
      assign w_cmdNext = rx_data;
    end else begin : g_multi
      assign w_cmdNext = {r_cmd[CMD_W-BYTE_W-1:0], rx_data};
    end
  endgenerate

  // Accept takes priority over timeout expiry; the timer only runs mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxState  <= R_IDLE;
      r_cmd      <= '0;
      r_cmdRdy   <= 1'b0;
      r_frameErr <= 1'b0;
      r_byteCnt  <= '0;
      r_toCnt    <= '0;
    end else begin
      r_frameErr <= 1'b0;
      case (r_rxState)
        R_IDLE, R_COLLECT: begin
          if (w_accept) begin
            r_cmd     <= w_cmdNext;
            r_toCnt   <= '0;
            r_byteCnt <= r_byteCnt + CNT_W'(1);
            if (w_lastByte) begin
              r_cmdRdy  <= 1'b1;
              r_rxState <= R_READY;
            end else begin
              r_rxState <= R_COLLECT;
            end
          end else if (r_rxState == R_COLLECT) begin
            if (w_expired) begin
              r_byteCnt  <= '0;
              r_toCnt    <= '0;
              r_frameErr <= 1'b1;
              r_rxState  <= R_IDLE;
            end else begin
              r_toCnt <= r_toCnt + TO_W'(1);
            end
          end
        end
        R_READY: begin
          r_toCnt <= '0;
          if (clr_cmd_rdy) begin
            r_cmdRdy  <= 1'b0;
            r_byteCnt <= '0;
            r_rxState <= R_IDLE;
          end
        end
        default: r_rxState <= R_IDLE;
      endcase
    end
  end

  assign clr_rx_rdy = w_accept;
  assign cmd        = r_cmd;
  assign cmd_rdy    = r_cmdRdy;
  assign frame_err  = r_frameErr;

  uart_frm_tx #(
    .RESP_BYTES(RESP_BYTES)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .resp     (resp),
    .resp_vld (resp_vld),
    .resp_busy(resp_busy),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .resp_done(resp_done)
  );

endmodule
